pe_address_sequencer: RTL and testbench
=======================================

# pe_address_sequencer

Per-PE local-store address sequencer: the next generation of the PE's kernel/neuron address generation, generalised to `NCH` independent address channels. Each channel has its own opcode, strides, row pitch and column limit, plus automatic row wrap. It sits inside each PE between the array-level control bus and the PE's local SRAM ports. Channel 0 drives the kernel store and channel 1 the neuron store; further channels serve additional local buffers.

## Interface
- `DEPTH`, 2, width of offsets and strides (`Tc`, `Tr`, row/col offsets).
- `A`, 7, local-store address width.
- `NCH`, 2, number of address channels.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `cmdValid` in NCH: per-channel command strobe.
- `cmdOp` in 3*NCH: per-channel opcode; channel i occupies bits [3i+2:3i].
- `peSelect` in 1: enables SET opcodes for this PE.
- `setValue` in DEPTH: offset value for SET opcodes.
- `writeMode` in NCH: 1 forces column stride 1 (load mode).
- `cfgStep` in NCH*A: row pitch.
- `cfgColStride` in NCH*DEPTH: `Tc`.
- `cfgRowStride` in NCH*DEPTH: `Tr`.
- `cfgColLimit` in NCH*A: auto-wrap column limit; 0 disables wrap.
- `addr` out NCH*A: registered address.
- `addrValid` out NCH: channel initialised since reset.
- `wrapPulse` out NCH: one-cycle pulse on auto-wrap.
- `addrOverflow` out NCH: sticky overflow flag (see Configuration).

## Operation
- Per-channel state: `row`, `col` (A bits each), `rowOfs`, `colOfs` (DEPTH bits each).
- When `cmdValid[i]`=0, the channel holds all state.
- Opcodes, applied only when `cmdValid[i]`=1:
  - 000 INIT: `row`=`col`=0; sets `addrValid[i]`.
  - 001 HOLD: no change.
  - 010 INCR: `col` += (`writeMode` ? 1 : `Tc`).
  - 011 JUMP: `row` += `Tr`; `col`=0.
  - 100 SET_ROW_OFST: `rowOfs`=`setValue`, only if `peSelect`=1.
  - 101 SET_COL_OFST: `colOfs`=`setValue`, only if `peSelect`=1.
  - 110 INCR_WRAP: compute c = `col` + stride, where stride follows the INCR rule.
    - If `cfgColLimit`≠0 and c ≥ `cfgColLimit`: `col`=0, `row` += `Tr`, `wrapPulse`=1.
    - Otherwise `col`=c.
  - 111 CLR_OFST: both offsets cleared, only if `peSelect`=1.
- `peSelect` gates only the SET and CLR opcodes. All other opcodes execute regardless of `peSelect`.
- Address computation: addr = (`row`+`rowOfs`)·`cfgStep` + `col` + `colOfs`.
  - Computed at full precision (2A+1 bits), then truncated to A bits.
  - `row` and `col` wrap modulo 2^A.
- Config inputs are sampled each cycle; changing them mid-sequence takes effect on the next address computation.

## Timing
- Latency is 1 cycle: `addr` after an edge reflects the state produced by the command sampled at that edge (next-state values are registered).
- `wrapPulse` is high for exactly the cycle following the wrapping edge. Back-to-back wraps give consecutive pulses.
- Reset values: `addr`=0, `addrValid`=0, `wrapPulse`=0, `addrOverflow`=0; all channel state is 0.
- `RST` clears everything asynchronously, including mid-sequence. The first command edge after deassertion is honoured.
- `addrValid` is cleared only by `RST`.
- Channels are fully independent. Simultaneous commands on different channels all execute in the same cycle.

## Configuration
- Macro: `PE_ADDR_OVERFLOW_CHECK_EN`.
- Defined: `addrOverflow[i]` sets when the full-precision address exceeds 2^A−1, and holds until INIT on that channel or `RST`.
- Undefined: no overflow logic is built; `addrOverflow` is tied to 0 and truncation is silent.

## Structure
- Package `pe_addr_pkg` holds:
  - the 3-bit opcode typedef and the eight opcode constants;
  - a function computing address width (2A+1).
- Sub-module `pe_addr_channel`: one channel's state, opcode decode, wrap logic and address register. It is instantiated `NCH` times via generate.

## Test plan
- `RST` pulse, then INIT on ch0 with `cfgStep`=8 → next cycle `addr0`=0, `addrValid0`=1, `addrValid1`=0.
- `peSelect`=1: SET_ROW_OFST with `setValue`=2, then SET_COL_OFST with `setValue`=1, `cfgStep`=8 → `addr0`=17. Repeat with `peSelect`=0 and `setValue`=3 → `addr0` stays 17.
- INCR_WRAP ×4 with stride 1, `cfgColLimit`=3, `Tr`=1, `cfgStep`=8, zero offsets → `addr0` = 1, 2, 8, 9. `wrapPulse0` is high only in the cycle `addr0`=8.
- `writeMode`=0, `Tc`=2, INCR ×2 from INIT → 2, 4. Then `writeMode`=1, INCR → 5. Meanwhile ch1 runs JUMP with `Tr`=1, `cfgStep`=16 → `addr1`=16 in the same cycle as ch0's first INCR.
- `cfgStep`=127, `row`=1 (via JUMP with `Tr`=1), then INCR to `col`=1 → full-precision address 128, so `addr0`=0. `addrOverflow0`=1 with the macro defined, 0 without.
- Assert `RST` asynchronously mid INCR_WRAP sequence → `addr`, `addrValid`, `wrapPulse` read 0 before the next `CLK` edge.

Source files
------------

// File: rtl/pe_addr_pkg.sv
// Shared definitions for the PE local-store address sequencer:
// the channel opcode type and the full-precision address width helper.
package pe_addr_pkg;

  typedef enum logic [2:0] {
    OP_INIT         = 3'b000,
    OP_HOLD         = 3'b001,
    OP_INCR         = 3'b010,
    OP_JUMP         = 3'b011,
    OP_SET_ROW_OFST = 3'b100,
    OP_SET_COL_OFST = 3'b101,
    OP_INCR_WRAP    = 3'b110,
    OP_CLR_OFST     = 3'b111
  } pe_op_e;

  // Width that holds (row+rowOfs)*step + col + colOfs without loss.
  function automatic int unsigned addr_full_width(input int unsigned a);
    return 2 * a + 1;
  endfunction

endpackage

// File: rtl/pe_addr_channel.sv
// One address channel: row/col/offset state, opcode decode, column
// auto-wrap and the registered local-store address.
// Optional overflow flag built only when PE_ADDR_OVERFLOW_CHECK_EN is defined.
module pe_addr_channel
  import pe_addr_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned A     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic             pe_select,
  input  logic [DEPTH-1:0] set_value,
  input  logic             write_mode,
  input  logic [A-1:0]     cfg_step,
  input  logic [DEPTH-1:0] cfg_col_stride,
  input  logic [DEPTH-1:0] cfg_row_stride,
  input  logic [A-1:0]     cfg_col_limit,
  output logic [A-1:0]     addr,
  output logic             addr_valid,
  output logic             wrap_pulse,
  output logic             addr_overflow
);

  localparam int unsigned W = addr_full_width(A);

  logic [A-1:0]     row_q, row_d;
  logic [A-1:0]     col_q, col_d;
  logic [DEPTH-1:0] row_ofs_q, row_ofs_d;
  logic [DEPTH-1:0] col_ofs_q, col_ofs_d;
  logic [A-1:0]     addr_q, addr_d;
  logic             addr_valid_q, addr_valid_d;
  logic             wrap_pulse_q, wrap_pulse_d;

  logic [A-1:0]     col_stride;
  logic [A-1:0]     col_next;
  logic [W-1:0]     full_addr;
  logic             is_init;
  pe_op_e           op;

  assign op = pe_op_e'(cmd_op);

  // Opcode decode: next channel state, valid and wrap pulse.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    row_ofs_d    = row_ofs_q;
    col_ofs_d    = col_ofs_q;
    addr_valid_d = addr_valid_q;
    wrap_pulse_d = 1'b0;
    is_init      = 1'b0;
    col_stride   = write_mode ? A'(1) : A'(cfg_col_stride);
    col_next     = col_q + col_stride;
    if (cmd_valid) begin
      case (op)
        OP_INIT: begin
          row_d        = '0;
          col_d        = '0;
          addr_valid_d = 1'b1;
          is_init      = 1'b1;
        end
        OP_HOLD: ;
        OP_INCR: col_d = col_next;
        OP_JUMP: begin
          row_d = row_q + A'(cfg_row_stride);
          col_d = '0;
        end
        OP_SET_ROW_OFST: if (pe_select) row_ofs_d = set_value;
        OP_SET_COL_OFST: if (pe_select) col_ofs_d = set_value;
        OP_INCR_WRAP: begin
          if ((cfg_col_limit != '0) && (col_next >= cfg_col_limit)) begin
            col_d        = '0;
            row_d        = row_q + A'(cfg_row_stride);
            wrap_pulse_d = 1'b1;
          end else begin
            col_d = col_next;
          end
        end
        OP_CLR_OFST: begin
          if (pe_select) begin
            row_ofs_d = '0;
            col_ofs_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Address from next-state values so it appears one cycle after the command.
  always_comb begin
    full_addr = (W'(row_d) + W'(row_ofs_d)) * W'(cfg_step)
              + W'(col_d) + W'(col_ofs_d);
    addr_d    = full_addr[A-1:0];
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      row_ofs_q    <= '0;
      col_ofs_q    <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      row_ofs_q    <= row_ofs_d;
      col_ofs_q    <= col_ofs_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

`ifdef PE_ADDR_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  // Sticky overflow; INIT restarts tracking from the fresh address.
  always_comb begin
    overflow_d = ((is_init ? 1'b0 : overflow_q) | (|full_addr[W-1:A]));
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign addr_overflow = overflow_q;
`else
  logic unused_ovf;
  assign unused_ovf    = (^full_addr[W-1:A]) ^ is_init;
  assign addr_overflow = 1'b0;
`endif

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: rtl/pe_address_sequencer.sv
// Per-PE local-store address sequencer with NCH independent channels.
// Channel 0 feeds the kernel store, channel 1 the neuron store.
// Optional overflow flags: define PE_ADDR_OVERFLOW_CHECK_EN.
module pe_address_sequencer
  import pe_addr_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned A     = 7,
  parameter int unsigned NCH   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       cmdValid,
  input  logic [3*NCH-1:0]     cmdOp,
  input  logic                 peSelect,
  input  logic [DEPTH-1:0]     setValue,
  input  logic [NCH-1:0]       writeMode,
  input  logic [NCH*A-1:0]     cfgStep,
  input  logic [NCH*DEPTH-1:0] cfgColStride,
  input  logic [NCH*DEPTH-1:0] cfgRowStride,
  input  logic [NCH*A-1:0]     cfgColLimit,
  output logic [NCH*A-1:0]     addr,
  output logic [NCH-1:0]       addrValid,
  output logic [NCH-1:0]       wrapPulse,
  output logic [NCH-1:0]       addrOverflow
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pe_addr_channel #(
      .DEPTH (DEPTH),
      .A     (A)
    ) u_ch (
      .clk            (CLK),
      .rst            (RST),
      .cmd_valid      (cmdValid[i]),
      .cmd_op         (cmdOp[3*i +: 3]),
      .pe_select      (peSelect),
      .set_value      (setValue),
      .write_mode     (writeMode[i]),
      .cfg_step       (cfgStep[A*i +: A]),
      .cfg_col_stride (cfgColStride[DEPTH*i +: DEPTH]),
      .cfg_row_stride (cfgRowStride[DEPTH*i +: DEPTH]),
      .cfg_col_limit  (cfgColLimit[A*i +: A]),
      .addr           (addr[A*i +: A]),
      .addr_valid     (addrValid[i]),
      .wrap_pulse     (wrapPulse[i]),
      .addr_overflow  (addrOverflow[i])
    );
  end

endmodule

// File: tb/tb_pe_address_sequencer.sv
// Directed self-checking bench for pe_address_sequencer (DEPTH=2, A=7, NCH=2).
module tb_pe_address_sequencer;
  import pe_addr_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned A     = 7;
  localparam int unsigned NCH   = 2;

`ifdef PE_ADDR_OVERFLOW_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NCH-1:0]       cmdValid;
  logic [3*NCH-1:0]     cmdOp;
  logic                 peSelect;
  logic [DEPTH-1:0]     setValue;
  logic [NCH-1:0]       writeMode;
  logic [NCH*A-1:0]     cfgStep;
  logic [NCH*DEPTH-1:0] cfgColStride;
  logic [NCH*DEPTH-1:0] cfgRowStride;
  logic [NCH*A-1:0]     cfgColLimit;
  logic [NCH*A-1:0]     addr;
  logic [NCH-1:0]       addrValid;
  logic [NCH-1:0]       wrapPulse;
  logic [NCH-1:0]       addrOverflow;

  int total = 0;
  int bad   = 0;

  pe_address_sequencer #(
    .DEPTH (DEPTH),
    .A     (A),
    .NCH   (NCH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cmdValid     (cmdValid),
    .cmdOp        (cmdOp),
    .peSelect     (peSelect),
    .setValue     (setValue),
    .writeMode    (writeMode),
    .cfgStep      (cfgStep),
    .cfgColStride (cfgColStride),
    .cfgRowStride (cfgRowStride),
    .cfgColLimit  (cfgColLimit),
    .addr         (addr),
    .addrValid    (addrValid),
    .wrapPulse    (wrapPulse),
    .addrOverflow (addrOverflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int ch, input pe_op_e op);
    cmdValid[ch]       = 1'b1;
    cmdOp[3*ch +: 3]   = op;
  endtask

  // One clock edge, settle, then drop all command strobes.
  task automatic cycle();
    @(posedge CLK);
    #1;
    cmdValid = '0;
  endtask

  function automatic logic [A-1:0] a_of(input int ch);
    return addr[A*ch +: A];
  endfunction

  initial begin
    RST          = 1'b1;
    cmdValid     = '0;
    cmdOp        = '0;
    peSelect     = 1'b0;
    setValue     = '0;
    writeMode    = '0;
    cfgStep      = '0;
    cfgColStride = '0;
    cfgRowStride = '0;
    cfgColLimit  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_addr", 32'(addr), 0);
    chk("rst_valid", 32'(addrValid), 0);
    chk("rst_wrap", 32'(wrapPulse), 0);
    chk("rst_ovf", 32'(addrOverflow), 0);
    RST = 1'b0;

    // INIT ch0 only
    cfgStep[0 +: A] = 7'd8;
    cmd(0, OP_INIT); cycle();
    chk("init_addr0", 32'(a_of(0)), 0);
    chk("init_valid", 32'(addrValid), 32'b01);

    // Offsets with peSelect=1
    peSelect = 1'b1;
    setValue = 2'd2; cmd(0, OP_SET_ROW_OFST); cycle();
    chk("set_row", 32'(a_of(0)), 16);
    setValue = 2'd1; cmd(0, OP_SET_COL_OFST); cycle();
    chk("set_col", 32'(a_of(0)), 17);
    // peSelect=0 gates SET/CLR
    peSelect = 1'b0;
    setValue = 2'd3; cmd(0, OP_SET_ROW_OFST); cycle();
    chk("nosel_row", 32'(a_of(0)), 17);
    cmd(0, OP_SET_COL_OFST); cycle();
    chk("nosel_col", 32'(a_of(0)), 17);
    cmd(0, OP_CLR_OFST); cycle();
    chk("nosel_clr", 32'(a_of(0)), 17);
    cmd(0, OP_HOLD); cycle();
    chk("hold", 32'(a_of(0)), 17);
    peSelect = 1'b1;
    cmd(0, OP_CLR_OFST); cycle();
    chk("clr", 32'(a_of(0)), 0);

    // INCR_WRAP with limit 3
    writeMode[0]            = 1'b1;
    cfgColLimit[0 +: A]     = 7'd3;
    cfgRowStride[0 +: DEPTH] = 2'd1;
    cmd(0, OP_INIT); cycle();
    cmd(0, OP_INCR_WRAP); cycle();
    chk("wrap1_addr", 32'(a_of(0)), 1);  chk("wrap1_p", 32'(wrapPulse[0]), 0);
    cmd(0, OP_INCR_WRAP); cycle();
    chk("wrap2_addr", 32'(a_of(0)), 2);  chk("wrap2_p", 32'(wrapPulse[0]), 0);
    cmd(0, OP_INCR_WRAP); cycle();
    chk("wrap3_addr", 32'(a_of(0)), 8);  chk("wrap3_p", 32'(wrapPulse[0]), 1);
    cmd(0, OP_INCR_WRAP); cycle();
    chk("wrap4_addr", 32'(a_of(0)), 9);  chk("wrap4_p", 32'(wrapPulse[0]), 0);
    cycle();
    chk("idle_addr", 32'(a_of(0)), 9);

    // INCR with Tc and writeMode, ch1 JUMP concurrently
    cfgColLimit[0 +: A]      = '0;
    writeMode                = '0;
    cfgColStride[0 +: DEPTH] = 2'd2;
    cfgStep[A +: A]          = 7'd16;
    cfgRowStride[DEPTH +: DEPTH] = 2'd1;
    cmd(0, OP_INIT); cmd(1, OP_INIT); cycle();
    chk("both_valid", 32'(addrValid), 32'b11);
    cmd(0, OP_INCR); cmd(1, OP_JUMP); cycle();
    chk("incr1", 32'(a_of(0)), 2);
    chk("jump_ch1", 32'(a_of(1)), 16);
    cmd(0, OP_INCR); cycle();
    chk("incr2", 32'(a_of(0)), 4);
    writeMode[0] = 1'b1;
    cmd(0, OP_INCR); cycle();
    chk("incr_wm", 32'(a_of(0)), 5);

    // Truncation / overflow
    cfgStep[0 +: A] = 7'd127;
    cmd(0, OP_INIT); cycle();
    cmd(0, OP_JUMP); cycle();
    chk("ovf_jump", 32'(a_of(0)), 127);
    chk("ovf_pre", 32'(addrOverflow[0]), 0);
    cmd(0, OP_INCR); cycle();
    chk("ovf_addr", 32'(a_of(0)), 0);
    chk("ovf_flag", 32'(addrOverflow[0]), 32'(EXP_OVF));
    chk("ovf_ch1", 32'(addrOverflow[1]), 0);
    cmd(0, OP_INIT); cycle();
    chk("ovf_init", 32'(addrOverflow[0]), 0);
    chk("ch1_kept", 32'(a_of(1)), 16);

    // Async reset mid INCR_WRAP sequence
    cfgStep[0 +: A]     = 7'd8;
    cfgColLimit[0 +: A] = 7'd3;
    cmd(0, OP_INIT); cycle();
    for (int i = 0; i < 3; i++) begin
      cmd(0, OP_INCR_WRAP); cycle();
    end
    chk("pre_rst_wrap", 32'(wrapPulse[0]), 1);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_addr", 32'(addr), 0);
    chk("arst_valid", 32'(addrValid), 0);
    chk("arst_wrap", 32'(wrapPulse), 0);
    #2;
    RST = 1'b0;
    cmd(1, OP_INIT); cycle();
    chk("post_rst_valid", 32'(addrValid), 32'b10);
    chk("post_rst_addr", 32'(addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
